// File: rtl/regfile_write_port_pkg.sv
// Shared processor constants and the write-request bundle
// used by the register-file write side.
package regfile_write_port_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 4;
    localparam int REG_COUNT = 10;
    localparam int FLAT_W    = REG_COUNT * DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // True when the address names an implemented register.
    function automatic logic addr_in_range(
        input logic [ADDR_W-1:0] a
    );
        return a < ADDR_W'(REG_COUNT);
    endfunction

endpackage

// File: rtl/regfile_write_buffer.sv
// One-entry write buffer with valid/ready handshake.
// Emits a commit strobe while the entry may drain.
module regfile_write_buffer
    import regfile_write_port_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_wr_valid,
    input  wr_req_t i_wr_req,
    input  logic    i_commit_en,
    output logic    o_wr_ready,
    output logic    o_fwd_valid,
    output wr_req_t o_fwd_req,
    output logic    o_commit
);

    logic    r_valid;
    wr_req_t r_req;
    logic    w_accept;

    // Draining the entry frees the slot in the same edge.
    assign o_commit    = r_valid && i_commit_en;
    assign o_wr_ready  = !r_valid || i_commit_en;
    assign w_accept    = i_wr_valid && o_wr_ready;
    assign o_fwd_valid = r_valid;
    assign o_fwd_req   = r_req;

    // Load on accept; clear only when draining with no refill.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_req   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_req   <= i_wr_req;
        end else if (o_commit) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the accumulator register file: buffered
// write-back, address decode, register array, bad-addr flag.
module regfile_write_port
    import regfile_write_port_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_commit_en,
    output logic [FLAT_W-1:0] o_regs_flat,
    output logic              o_fwd_valid,
    output logic [ADDR_W-1:0] o_fwd_addr,
    output logic [DATA_W-1:0] o_fwd_data,
    output logic              o_bad_addr
);

    wr_req_t           w_req;
    wr_req_t           w_fwd;
    logic              w_commit;
    logic              w_in_range;
    logic [DATA_W-1:0] r_regs [REG_COUNT];
    logic              r_bad_addr;

    assign w_req = '{addr: i_wr_addr, data: i_wr_data};

    regfile_write_buffer u_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr_valid  (i_wr_valid),
        .i_wr_req    (w_req),
        .i_commit_en (i_commit_en),
        .o_wr_ready  (o_wr_ready),
        .o_fwd_valid (o_fwd_valid),
        .o_fwd_req   (w_fwd),
        .o_commit    (w_commit)
    );

    assign w_in_range = addr_in_range(w_fwd.addr);
    assign o_fwd_addr = w_fwd.addr;
    assign o_fwd_data = w_fwd.data;
    assign o_bad_addr = r_bad_addr;

    // Commit the buffered entry into the addressed register only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < REG_COUNT; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < REG_COUNT; k++) begin
                if (w_commit && w_in_range &&
                    w_fwd.addr == ADDR_W'(k)) begin
                    r_regs[k] <= w_fwd.data;
                end
            end
        end
    end

    // Flag a dropped out-of-range commit for exactly one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bad_addr <= 1'b0;
        end else begin
            r_bad_addr <= w_commit && !w_in_range;
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
        assign o_regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
    end

endmodule

// File: doc/regfile_write_port.md
# regfile_write_port

Write side of the accumulator processor's 10-entry, 16-bit register file. It accepts write-back requests over a valid/ready handshake, stages each request in a one-entry write buffer, and commits it to the addressed register when the control unit allows. It exposes all ten register values to the read-select mux, and exposes the buffered entry so read logic can forward it. Writes to out-of-range addresses are dropped and flagged.

## Interface
- DATA_W, 16, register width in bits
- REG_COUNT, 10, number of registers; legal addresses are 0..REG_COUNT-1
- ADDR_W, 4, address width

- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- wr_valid  in  1  write request present
- wr_ready  out  1  block can accept a request this cycle
- wr_addr  in  ADDR_W  destination register
- wr_data  in  DATA_W  value to write
- commit_en  in  1  control unit permits the buffered write to commit this cycle
- regs_flat  out  REG_COUNT*DATA_W  all register values; register k is at bits [16k+15:16k]
- fwd_valid  out  1  buffer holds an uncommitted write
- fwd_addr  out  ADDR_W  address of the buffered write
- fwd_data  out  DATA_W  data of the buffered write
- bad_addr  out  1  one-cycle pulse; a write to an address ≥ REG_COUNT was dropped

## Operation
- The write buffer has one entry: buf_valid, buf_addr, buf_data. fwd_* is driven directly from the buffer.
- wr_ready = !buf_valid || commit_en (combinational).
- Accept: wr_valid && wr_ready at a rising edge. The buffer loads wr_addr/wr_data, and buf_valid goes to 1.
- Commit: buf_valid && commit_en at a rising edge.
  - If buf_addr < REG_COUNT: register[buf_addr] ← buf_data.
  - Otherwise: no register changes, and bad_addr = 1 for the next cycle.
- Commit with no accept in the same edge: buf_valid goes to 0.
- Commit and accept in the same edge: the old entry commits and the new entry loads. buf_valid stays 1, and there is no bubble.
- commit_en while the buffer is empty: no effect.
- Back-to-back accepts with commit_en held high give one write per cycle.
- Repeated writes to the same address: the last committed value wins. Order is preserved.
- wr_addr/wr_data are don't-care when wr_valid = 0.
- bad_addr is 0 in every cycle that does not follow an out-of-range commit.

## Timing
- Reset (async assert, sync release): all registers 0, buf_valid 0, buf_addr 0, buf_data 0, bad_addr 0. wr_ready therefore reads 1 during reset.
- Reset asserted mid-operation discards any buffered write. No partial commit occurs.
- Latency:
  - Request accepted at edge t is visible on fwd_* after t.
  - With commit_en high at edge t+1, the value appears on regs_flat after t+1, i.e. one cycle after acceptance at minimum.
- Stall: while commit_en = 0 and buf_valid = 1, wr_ready = 0 and the buffer holds unchanged.
- regs_flat changes only on commit edges, and only in the addressed slice.
- No combinational path from wr_* to regs_flat or fwd_*. wr_ready depends only on buf_valid and commit_en.

## Structure
- Shared package (processor constants): DATA_W, ADDR_W, REG_COUNT, and a write-request struct {addr, data}.
- Sub-module regfile_write_buffer:
  - Holds the one-entry buffer and the handshake.
  - Produces wr_ready, fwd_*, and a commit strobe.
- Top level:
  - Decodes the address against REG_COUNT.
  - Holds the register array and the bad_addr flop.
  - Flattens the registers onto regs_flat.

## Test plan
- Reset then idle: regs_flat = 0, fwd_valid = 0, wr_ready = 1, bad_addr = 0. Assert Reset asynchronously mid-cycle: outputs clear immediately.
- Single write, addr 3, data 0xBEEF, commit_en = 1 → fwd_valid = 1 with fwd_addr = 3 for one cycle. The next cycle shows regs_flat[63:48] = 0xBEEF; all other slices stay 0.
- Stall: hold commit_en = 0 after accepting addr 9 / 0x1234 → wr_ready = 0 and fwd_* stays stable for 5 cycles, with a second request held off. Raise commit_en → reg 9 = 0x1234, and the second request is accepted in that same edge.
- Streaming: 10 consecutive writes, addr k with data 0x0100+k, commit_en = 1 → one accept per cycle and no bubbles. Afterwards, reg k = 0x0100+k for k = 0..9.
- Out-of-range: write addr 10 / 0xFFFF, then addr 15 / 0xAAAA → each gives a one-cycle bad_addr pulse after its commit, and regs_flat is unchanged.
- Same-address ordering and reset mid-buffer:
  - Write addr 0 = 0x0001, then 0x0002 back-to-back → reg 0 = 0x0002.
  - Buffer a write to addr 5 with commit_en = 0, then pulse Reset → reg 5 = 0 and fwd_valid = 0.
